// File: rtl/satswarmv2_pkg.sv
// Shared types and constants for the SatSwarmV2 variable decision engine.
// Holds the scan FSM encoding and the batch-bump width helper.
package satswarmv2_pkg;

    localparam int VAR_W  = 32;
    localparam int BUMP_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counts above the list length collapse to the full list.
    function automatic logic [3:0] clamp_bump(input logic [3:0] count);
        return (count > 4'(BUMP_N)) ? 4'(BUMP_N) : count;
    endfunction

endpackage

// File: rtl/vde_activity_bank.sv
// Per-variable activity counters: optional halving, then +1 per bump hit,
// saturating at the counter maximum. One combinational read port by index.
module vde_activity_bank
    import satswarmv2_pkg::*;
#(
    parameter int MAX_VARS = 16,
    parameter int ACT_W    = 32,
    parameter int IDX_W    = $clog2(MAX_VARS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IDX_W-1:0]              eff_max,
    input  logic                          decay,
    input  logic                          bump_valid,
    input  logic [VAR_W-1:0]              bump_var,
    input  logic [3:0]                    bump_count,
    input  logic [BUMP_N-1:0][VAR_W-1:0]  bump_vars,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [ACT_W-1:0]              rd_act
);

    localparam logic [ACT_W+3:0] ACT_MAX = {4'b0, {ACT_W{1'b1}}};

    logic [ACT_W-1:0] act   [MAX_VARS];
    logic [ACT_W-1:0] act_n [MAX_VARS];
    logic [ACT_W-1:0] base;
    logic [3:0]       hits;
    logic [3:0]       bc;
    logic [ACT_W+3:0] sum;

    always_comb begin
        bc   = clamp_bump(bump_count);
        base = '0;
        hits = '0;
        sum  = '0;
        for (int i = 0; i < MAX_VARS; i++) begin
            act_n[i] = act[i];
        end
        for (int i = 1; i < MAX_VARS; i++) begin
            base = decay ? (act[i] >> 1) : act[i];
            hits = '0;
            // Bumps aimed at index 0 or beyond the current problem are dropped.
            if (IDX_W'(i) <= eff_max) begin
                if (bump_valid && bump_var == VAR_W'(i)) hits = hits + 4'd1;
                for (int j = 0; j < BUMP_N; j++) begin
                    if (4'(j) < bc && bump_vars[j] == VAR_W'(i)) hits = hits + 4'd1;
                end
            end
            sum      = {4'b0, base} + (ACT_W+4)'(hits);
            act_n[i] = (sum > ACT_MAX) ? {ACT_W{1'b1}} : sum[ACT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_VARS; i++) begin
            if (reset) act[i] <= '0;
            else       act[i] <= act_n[i];
        end
    end

    assign rd_act = act[rd_idx];

endmodule

// File: rtl/vde_engine.sv
// Variable decision engine: linear scan for the unassigned variable with the
// highest activity, plus assigned/saved-phase bookkeeping for the trail.
module vde_engine
    import satswarmv2_pkg::*;
#(
    parameter int MAX_VARS = 16,
    parameter int ACT_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          request,
    output logic                          decision_valid,
    output logic [VAR_W-1:0]              decision_var,
    output logic                          decision_phase,
    input  logic [3:0]                    phase_offset,
    output logic                          all_assigned,
    input  logic [VAR_W-1:0]              max_var,
    input  logic                          clear_all,
    input  logic                          assign_valid,
    input  logic [VAR_W-1:0]              assign_var,
    input  logic                          assign_value,
    input  logic                          clear_valid,
    input  logic [VAR_W-1:0]              clear_var,
    input  logic                          bump_valid,
    input  logic [VAR_W-1:0]              bump_var,
    input  logic [3:0]                    bump_count,
    input  logic [BUMP_N-1:0][VAR_W-1:0]  bump_vars,
    input  logic                          decay,
    output state_e                        state_dbg
);

    localparam int IDX_W = $clog2(MAX_VARS);

    state_e              state, state_n;
    logic [IDX_W-1:0]    eff_max;
    logic [IDX_W-1:0]    idx;
    logic [MAX_VARS-1:0] in_rng;
    logic [MAX_VARS-1:0] assigned, phase_valid, saved_phase;
    logic [ACT_W-1:0]    rd_act;
    logic                best_found, best_found_n, take;
    logic [IDX_W-1:0]    best_var, best_var_n;
    logic [ACT_W-1:0]    best_act, best_act_n;
    logic                pick_phase;

    assign eff_max = (max_var > VAR_W'(MAX_VARS-1)) ? IDX_W'(MAX_VARS-1) : max_var[IDX_W-1:0];

    always_comb begin
        in_rng = '0;
        for (int i = 1; i < MAX_VARS; i++) begin
            in_rng[i] = (IDX_W'(i) <= eff_max);
        end
    end

    // Per variable: clear_all beats clear_valid beats assign_valid; the saved
    // phase follows every in-range assign even when the assigned bit is overridden.
    always_ff @(posedge clk) begin
        if (reset) begin
            assigned    <= '0;
            phase_valid <= '0;
            saved_phase <= '0;
        end else begin
            for (int i = 1; i < MAX_VARS; i++) begin
                if (clear_all)
                    assigned[i] <= 1'b0;
                else if (clear_valid && in_rng[i] && clear_var == VAR_W'(i))
                    assigned[i] <= 1'b0;
                else if (assign_valid && in_rng[i] && assign_var == VAR_W'(i))
                    assigned[i] <= 1'b1;
                if (assign_valid && in_rng[i] && assign_var == VAR_W'(i)) begin
                    saved_phase[i] <= assign_value;
                    phase_valid[i] <= 1'b1;
                end
            end
        end
    end

    vde_activity_bank #(
        .MAX_VARS (MAX_VARS),
        .ACT_W    (ACT_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .eff_max    (eff_max),
        .decay      (decay),
        .bump_valid (bump_valid),
        .bump_var   (bump_var),
        .bump_count (bump_count),
        .bump_vars  (bump_vars),
        .rd_idx     (idx),
        .rd_act     (rd_act)
    );

    // Ties keep the earlier (lower) index; the first unassigned var always wins over "none".
    always_comb begin
        take         = in_rng[idx] && !assigned[idx] && (!best_found || rd_act > best_act);
        best_found_n = best_found | take;
        best_var_n   = take ? idx : best_var;
        best_act_n   = take ? rd_act : best_act;
        pick_phase   = phase_valid[best_var_n] ? saved_phase[best_var_n]
                                               : phase_offset[best_var_n[1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Handshake: request is a level held by the caller; the result (decision_valid
    // or all_assigned) stays up while request stays high and clears one cycle after
    // request falls. Dropping request before the result abandons the scan silently.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (request) state_n = SCAN;
            SCAN:    if (!request) state_n = IDLE;
                     else if (idx >= eff_max) state_n = DONE;
            DONE:    if (!request) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= '0;
            best_found     <= 1'b0;
            best_var       <= '0;
            best_act       <= '0;
            decision_valid <= 1'b0;
            all_assigned   <= 1'b0;
            decision_var   <= '0;
            decision_phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx        <= IDX_W'(1);
                    best_found <= 1'b0;
                    best_var   <= '0;
                    best_act   <= '0;
                end
                SCAN: begin
                    if (request) begin
                        idx        <= idx + IDX_W'(1);
                        best_found <= best_found_n;
                        best_var   <= best_var_n;
                        best_act   <= best_act_n;
                        if (idx >= eff_max) begin
                            decision_valid <= best_found_n;
                            all_assigned   <= !best_found_n;
                            decision_var   <= VAR_W'(best_var_n);
                            decision_phase <= pick_phase;
                        end
                    end
                end
                DONE: begin
                    if (!request) begin
                        decision_valid <= 1'b0;
                        all_assigned   <= 1'b0;
                        decision_var   <= '0;
                        decision_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_vde_engine.sv
// Directed scoreboard bench for vde_engine: drivers push expected decisions,
// a negedge monitor pops and compares each new result.
module tb_vde_engine;
    import satswarmv2_pkg::*;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         request = 1'b0;
    logic                         decision_valid;
    logic [31:0]                  decision_var;
    logic                         decision_phase;
    logic [3:0]                   phase_offset = 4'b1010;
    logic                         all_assigned;
    logic [31:0]                  max_var = 32'd10;
    logic                         clear_all = 1'b0;
    logic                         assign_valid = 1'b0;
    logic [31:0]                  assign_var = '0;
    logic                         assign_value = 1'b0;
    logic                         clear_valid = 1'b0;
    logic [31:0]                  clear_var = '0;
    logic                         bump_valid = 1'b0;
    logic [31:0]                  bump_var = '0;
    logic [3:0]                   bump_count = '0;
    logic [7:0][31:0]             bump_vars = '0;
    logic                         decay = 1'b0;
    state_e                       state_dbg;

    logic [34:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_results = 0;
    logic        out_prev = 1'b0;
    logic [34:0] mon_got, mon_exp;

    always #5 clk = ~clk;

    vde_engine #(.MAX_VARS(16), .ACT_W(4)) dut (
        .clk(clk), .reset(reset), .request(request),
        .decision_valid(decision_valid), .decision_var(decision_var),
        .decision_phase(decision_phase), .phase_offset(phase_offset),
        .all_assigned(all_assigned), .max_var(max_var), .clear_all(clear_all),
        .assign_valid(assign_valid), .assign_var(assign_var), .assign_value(assign_value),
        .clear_valid(clear_valid), .clear_var(clear_var), .bump_valid(bump_valid),
        .bump_var(bump_var), .bump_count(bump_count), .bump_vars(bump_vars),
        .decay(decay), .state_dbg(state_dbg)
    );

    // Packing: {all_assigned, decision_valid, decision_phase, decision_var}
    function automatic logic [34:0] mk(input logic aa, input logic dv, input logic ph,
                                       input logic [31:0] v);
        return {aa, dv, ph, v};
    endfunction

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: compare on each rising edge of the result.
    always @(negedge clk) begin
        if ((decision_valid | all_assigned) && !out_prev) begin
            n_results++;
            mon_got = mk(all_assigned, decision_valid, decision_phase, decision_var);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result got=%h want=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp[34]) mon_got[32:0] = '0;
                check("decision", mon_got, mon_exp);
            end
        end
        out_prev = decision_valid | all_assigned;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_request(input logic [34:0] e);
        int seen;
        int cyc;
        exp_q.push_back(e);
        seen = n_results;
        cyc = 0;
        request = 1'b1;
        while (n_results == seen && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (n_results == seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL request_timeout got=no_result want=result");
            void'(exp_q.pop_front());
        end
        repeat (2) @(negedge clk);
        check("hold", {33'd0, all_assigned, decision_valid}, {33'd0, e[34], e[33]});
        @(posedge clk);
        #1;
        request = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("clear", {33'd0, all_assigned, decision_valid}, 35'd0);
        tick();
    endtask

    task automatic do_assign(input logic [31:0] v, input logic val);
        assign_valid = 1'b1; assign_var = v; assign_value = val;
        tick();
        assign_valid = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] v);
        clear_valid = 1'b1; clear_var = v;
        tick();
        clear_valid = 1'b0;
    endtask

    task automatic do_bump(input logic [31:0] v, input int n);
        bump_valid = 1'b1; bump_var = v;
        repeat (n) tick();
        bump_valid = 1'b0;
    endtask

    task automatic do_batch(input logic [3:0] cnt, input logic [7:0][31:0] vars,
                            input logic dec, input logic bv, input logic [31:0] bvar);
        bump_count = cnt; bump_vars = vars; decay = dec; bump_valid = bv; bump_var = bvar;
        tick();
        bump_count = '0; bump_vars = '0; decay = 1'b0; bump_valid = 1'b0;
    endtask

    initial begin
        logic [7:0][31:0] bl;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", mk(all_assigned, decision_valid, decision_phase, decision_var), 35'd0);
        check("reset_state", {33'd0, state_dbg}, {33'd0, IDLE});
        tick();

        // All activities zero: lowest index wins, default phase offset[1]=1.
        do_request(mk(0, 1, 1, 32'd1));
        do_assign(32'd1, 1'b1);
        do_request(mk(0, 1, 0, 32'd2));
        phase_offset = 4'b0101;
        do_clear(32'd1);
        do_request(mk(0, 1, 1, 32'd1));

        do_clear(32'd5);
        do_bump(32'd5, 5);
        do_request(mk(0, 1, 0, 32'd5));

        for (int i = 1; i <= 10; i++) do_assign(32'(i), i[0]);
        do_request(mk(1, 0, 0, 32'd0));

        // Out-of-range assigns are dropped: var 12 stays free when the range grows.
        do_assign(32'd12, 1'b1);
        do_assign(32'd0, 1'b1);
        max_var = 32'd12;
        do_assign(32'd11, 1'b0);
        do_request(mk(0, 1, 1, 32'd12));
        max_var = 32'd10;

        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        do_request(mk(0, 1, 1, 32'd5));

        // act5: 5 -> 2 -> 4, then decay+batch {5,5,7}: act5=4, act7=1; entry 3 is past count.
        do_batch(4'd0, '0, 1'b1, 1'b0, 32'd0);
        do_bump(32'd5, 2);
        bl = '0; bl[0] = 32'd5; bl[1] = 32'd5; bl[2] = 32'd7; bl[3] = 32'd7;
        do_batch(4'd3, bl, 1'b1, 1'b0, 32'd0);
        do_request(mk(0, 1, 1, 32'd5));
        do_bump(32'd7, 3);
        do_request(mk(0, 1, 1, 32'd5));
        do_bump(32'd7, 1);
        do_request(mk(0, 1, 1, 32'd7));

        // bump_count 15 behaves as 8: act3 = 8.
        for (int j = 0; j < 8; j++) bl[j] = 32'd3;
        do_batch(4'd15, bl, 1'b0, 1'b0, 32'd0);
        do_request(mk(0, 1, 1, 32'd3));

        // Saturation at 15 (ACT_W=4): act2 = 9+9 -> 15 beats act4 = 9+5 = 14.
        for (int j = 0; j < 8; j++) bl[j] = 32'd2;
        do_batch(4'd8, bl, 1'b0, 1'b1, 32'd2);
        do_batch(4'd8, bl, 1'b0, 1'b1, 32'd2);
        for (int j = 0; j < 8; j++) bl[j] = 32'd4;
        do_batch(4'd8, bl, 1'b0, 1'b1, 32'd4);
        do_batch(4'd4, bl, 1'b0, 1'b1, 32'd4);
        do_request(mk(0, 1, 0, 32'd2));

        max_var = 32'd0;
        do_request(mk(1, 0, 0, 32'd0));
        max_var = 32'd10;

        // Abort mid-scan: nothing may appear.
        request = 1'b1;
        repeat (3) tick();
        request = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("abort_outputs", {33'd0, all_assigned, decision_valid}, 35'd0);
        check("abort_state", {33'd0, state_dbg}, {33'd0, IDLE});
        tick();
        do_request(mk(0, 1, 0, 32'd2));

        check("queue_empty", 35'(exp_q.size()), 35'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
